// File: rtl/pid_controller.sv
// pid_controller
//
// Purpose:
//   Position / velocity / displacement control loop for the motor board.
//   It takes the decoded setpoint, mode, gains and limits, along with the
//   encoder and spring-displacement measurements. It produces the signed duty
//   word for the PWM stage. One computation runs per accepted tick. A single
//   shared multiplier evaluates the P, I and D products on successive cycles.
//
// Ports:
//   CLK               system clock
//   reset             synchronous active-low reset
//   tick              control-rate strobe, ignored while a computation runs
//   control_mode      0 position, 1 velocity, 2 displacement, 3 direct duty,
//                     any other value forces duty to zero
//   setpoint          signed target
//   encoder0_position signed motor encoder count
//   displacement      signed spring displacement
//   Kp, Ki, Kd        signed gains
//   PWMLimit          unsigned duty magnitude limit (capped at 2^(W-1)-1)
//   IntegralLimit     unsigned integrator magnitude limit (same cap)
//   deadband          unsigned error deadband
//   duty              registered signed controller output
//   duty_valid        one-cycle pulse when duty is written
//   busy              high while a computation is in flight
module pid_controller #(
  parameter int W = 24
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                tick,
  input  logic [7:0]          control_mode,
  input  logic signed [W-1:0] setpoint,
  input  logic signed [W-1:0] encoder0_position,
  input  logic signed [W-1:0] displacement,
  input  logic signed [W-1:0] Kp,
  input  logic signed [W-1:0] Ki,
  input  logic signed [W-1:0] Kd,
  input  logic [W-1:0]        PWMLimit,
  input  logic [W-1:0]        IntegralLimit,
  input  logic [W-1:0]        deadband,
  output logic signed [W-1:0] duty,
  output logic                duty_valid,
  output logic                busy
);

  localparam int AW = 52;
  localparam int PW = 2 * W + 1;
  localparam logic [W-1:0] MAG_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_INTEG, S_MUL_P, S_MUL_I, S_MUL_D, S_OUT
  } state_t;

  state_t state;

  logic [7:0]          mode_s, prev_mode;
  logic signed [W-1:0] sp_s, enc_s, disp_s, kp_s, ki_s, kd_s;
  logic [W-1:0]        pwm_lim_s, int_lim_s, db_s;
  logic signed [W-1:0] prev_enc, old_enc;
  logic signed [W-1:0] err_reg, integ, last_err;
  logic signed [AW-1:0] acc;

  logic signed [W+1:0] meas_x, err_x, integ_sum;
  logic signed [W-1:0] err_sat, err_db, integ_next;
  logic [W-1:0]        err_abs;
  logic signed [W-1:0] mul_a;
  logic signed [W:0]   mul_b;
  logic signed [PW-1:0] product;
  logic signed [AW-1:0] product_x;
  logic                pid_mode;

  // Limits above the largest positive W-bit value behave as that value, so
  // every clamp result is representable in a signed W-bit word.
  function automatic logic [W-1:0] cap_limit(input logic [W-1:0] v);
    return (v > MAG_MAX) ? MAG_MAX : v;
  endfunction

  // Symmetric clamp of a wide signed value to +/-lim, lim already capped.
  function automatic logic signed [W-1:0] clamp_lim(input logic signed [AW-1:0] v,
                                                    input logic [W-1:0] lim);
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] lo;
    hi = $signed({{(AW-W){1'b0}}, lim});
    lo = -hi;
    if (v > hi) return hi[W-1:0];
    else if (v < lo) return lo[W-1:0];
    else return v[W-1:0];
  endfunction

  assign pid_mode = (mode_s <= 8'd2);

  // Error path: pick the measurement for the mode, subtract it with enough
  // headroom that nothing wraps, saturate, then apply the deadband.
  always_comb begin
    meas_x = '0;
    case (mode_s)
      8'd0:    meas_x = (W+2)'(enc_s);
      8'd1:    meas_x = (W+2)'(enc_s) - (W+2)'(old_enc);
      8'd2:    meas_x = (W+2)'(disp_s);
      default: meas_x = '0;
    endcase
    err_x   = (W+2)'(sp_s) - meas_x;
    err_sat = clamp_lim(AW'(err_x), MAG_MAX);
    err_abs = err_sat[W-1] ? -err_sat : err_sat;
    err_db  = (err_abs <= db_s) ? '0 : err_sat;
  end

  assign integ_sum  = (W+2)'(integ) + (W+2)'(err_reg);
  assign integ_next = clamp_lim(AW'(integ_sum), int_lim_s);

  // The single multiplier is steered by the state; the D operand is the
  // error difference, which needs one extra bit.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_MUL_P: begin
        mul_a = kp_s;
        mul_b = (W+1)'(err_reg);
      end
      S_MUL_I: begin
        mul_a = ki_s;
        mul_b = (W+1)'(integ);
      end
      S_MUL_D: begin
        mul_a = kd_s;
        mul_b = (W+1)'(err_reg) - (W+1)'(last_err);
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign product   = PW'(mul_a) * PW'(mul_b);
  assign product_x = AW'(product);

  // Control sequencer. Inputs are captured on the accepting edge. prev_enc is
  // refreshed on every accepted tick, while old_enc keeps the value velocity
  // mode differences against.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= S_IDLE;
      mode_s     <= '0;
      prev_mode  <= '0;
      sp_s       <= '0;
      enc_s      <= '0;
      disp_s     <= '0;
      kp_s       <= '0;
      ki_s       <= '0;
      kd_s       <= '0;
      pwm_lim_s  <= '0;
      int_lim_s  <= '0;
      db_s       <= '0;
      prev_enc   <= '0;
      old_enc    <= '0;
      err_reg    <= '0;
      integ      <= '0;
      last_err   <= '0;
      acc        <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            mode_s    <= control_mode;
            sp_s      <= setpoint;
            enc_s     <= encoder0_position;
            disp_s    <= displacement;
            kp_s      <= Kp;
            ki_s      <= Ki;
            kd_s      <= Kd;
            pwm_lim_s <= cap_limit(PWMLimit);
            int_lim_s <= cap_limit(IntegralLimit);
            db_s      <= deadband;
            old_enc   <= prev_enc;
            prev_enc  <= encoder0_position;
            busy      <= 1'b1;
            state     <= S_ERR;
          end
        end
        S_ERR: begin
          err_reg   <= err_db;
          prev_mode <= mode_s;
          if (!pid_mode) begin
            integ    <= '0;
            last_err <= '0;
            state    <= S_OUT;
          end else begin
            // History from another mode is meaningless here.
            if (mode_s != prev_mode) begin
              integ    <= '0;
              last_err <= '0;
            end
            state <= S_INTEG;
          end
        end
        S_INTEG: begin
          integ <= integ_next;
          state <= S_MUL_P;
        end
        S_MUL_P: begin
          acc   <= product_x;
          state <= S_MUL_I;
        end
        S_MUL_I: begin
          acc   <= acc + product_x;
          state <= S_MUL_D;
        end
        S_MUL_D: begin
          acc   <= acc + product_x;
          state <= S_OUT;
        end
        S_OUT: begin
          if (pid_mode) begin
            duty     <= clamp_lim(acc, pwm_lim_s);
            last_err <= err_reg;
          end else if (mode_s == 8'd3) begin
            duty <= clamp_lim(AW'(sp_s), pwm_lim_s);
          end else begin
            duty <= '0;
          end
          duty_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_controller.sv
// tb_pid_controller
//
// Purpose:
//   Self-checking bench for pid_controller. A driver issues ticks and pushes
//   the expected duty word into a scoreboard queue, along with the cycle it
//   is due on. The expected word comes from a plain-arithmetic reference
//   model. A monitor pops and compares each duty_valid pulse.
module tb_pid_controller;

  localparam int W = 24;
  localparam longint MAXV = 8388607;
  localparam longint LIM_ALL = 16777215;

  logic                CLK = 1'b0;
  logic                reset;
  logic                tick;
  logic [7:0]          control_mode;
  logic signed [W-1:0] setpoint;
  logic signed [W-1:0] encoder0_position;
  logic signed [W-1:0] displacement;
  logic signed [W-1:0] Kp;
  logic signed [W-1:0] Ki;
  logic signed [W-1:0] Kd;
  logic [W-1:0]        PWMLimit;
  logic [W-1:0]        IntegralLimit;
  logic [W-1:0]        deadband;
  logic signed [W-1:0] duty;
  logic                duty_valid;
  logic                busy;

  pid_controller #(.W(W)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .tick              (tick),
    .control_mode      (control_mode),
    .setpoint          (setpoint),
    .encoder0_position (encoder0_position),
    .displacement      (displacement),
    .Kp                (Kp),
    .Ki                (Ki),
    .Kd                (Kd),
    .PWMLimit          (PWMLimit),
    .IntegralLimit     (IntegralLimit),
    .deadband          (deadband),
    .duty              (duty),
    .duty_valid        (duty_valid),
    .busy              (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int validCount = 0;

  typedef struct {
    longint value;
    int     due;
  } exp_t;

  exp_t scoreQ[$];
  exp_t head;

  longint mInteg = 0;
  longint mLast = 0;
  longint mPrevEnc = 0;
  int     mPrevMode = 0;

  function automatic longint clampL(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic longint rand24s();
    logic signed [W-1:0] v;
    v = W'($urandom);
    return longint'(v);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mInteg = 0;
    mLast = 0;
    mPrevEnc = 0;
    mPrevMode = 0;
  endtask

  // Reference model: one call per accepted tick, straight from the control law.
  task automatic modelTick(input int mode, input longint sp, input longint enc, input longint disp,
                           input longint kp, input longint ki, input longint kd,
                           input longint pwm, input longint ilim, input longint db,
                           output longint res, output int lat);
    longint pl, il, meas, e, absE;
    pl = (pwm > MAXV) ? MAXV : pwm;
    il = (ilim > MAXV) ? MAXV : ilim;
    if (mode <= 2) begin
      if (mode != mPrevMode) begin
        mInteg = 0;
        mLast = 0;
      end
      if (mode == 0) meas = enc;
      else if (mode == 1) meas = enc - mPrevEnc;
      else meas = disp;
      e = clampL(sp - meas, MAXV);
      absE = (e < 0) ? -e : e;
      if (absE <= db) e = 0;
      mInteg = clampL(mInteg + e, il);
      res = clampL(kp * e + ki * mInteg + kd * (e - mLast), pl);
      mLast = e;
      lat = 6;
    end else begin
      res = (mode == 3) ? clampL(sp, pl) : 0;
      mInteg = 0;
      mLast = 0;
      lat = 2;
    end
    mPrevEnc = enc;
    mPrevMode = mode;
  endtask

  task automatic scrambleInputs();
    control_mode = 8'($urandom);
    setpoint = W'($urandom);
    encoder0_position = W'($urandom);
    displacement = W'($urandom);
    Kp = W'($urandom);
    Ki = W'($urandom);
    Kd = W'($urandom);
    PWMLimit = W'($urandom);
    IntegralLimit = W'($urandom);
    deadband = W'($urandom);
  endtask

  task automatic waitIdle(input bit scramble);
    for (int i = 0; i < 40 && scoreQ.size() != 0; i++) begin
      @(negedge CLK);
      if (scramble) scrambleInputs();
    end
    if (scoreQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: got %0d pending results, expected 0", scoreQ.size());
      scoreQ.delete();
    end
  endtask

  // Drives one tick at the next negedge; the accepting edge is returned.
  task automatic applyStimulus(input int mode, input longint sp, input longint enc, input longint disp,
                               input longint kp, input longint ki, input longint kd,
                               input longint pwm, input longint ilim, input longint db,
                               input bit waitDone, input bit scramble, output int edgeN);
    exp_t item;
    longint res;
    int lat;
    @(negedge CLK);
    control_mode = 8'(mode);
    setpoint = W'(sp);
    encoder0_position = W'(enc);
    displacement = W'(disp);
    Kp = W'(kp);
    Ki = W'(ki);
    Kd = W'(kd);
    PWMLimit = W'(pwm);
    IntegralLimit = W'(ilim);
    deadband = W'(db);
    tick = 1'b1;
    modelTick(mode, sp, enc, disp, kp, ki, kd, pwm, ilim, db, res, lat);
    item.value = res;
    item.due = cyc + 1 + lat;
    scoreQ.push_back(item);
    edgeN = cyc + 1;
    @(negedge CLK);
    tick = 1'b0;
    if (scramble) scrambleInputs();
    if (waitDone) waitIdle(scramble);
  endtask

  task automatic doReset();
    @(negedge CLK);
    reset = 1'b0;
    scoreQ.delete();
    modelReset();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  // Monitor: each result must arrive on exactly the cycle it was due.
  always @(posedge CLK) begin
    #1;
    if (scoreQ.size() != 0 && cyc > scoreQ[0].due) begin
      head = scoreQ.pop_front();
      checkOutput("duty_valid_timeout_cycle", cyc, head.due);
    end
    if (duty_valid) begin
      validCount++;
      if (scoreQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_duty_valid: got duty %0d at cycle %0d, expected no pulse", duty, cyc);
      end else begin
        head = scoreQ.pop_front();
        checkOutput("duty_valid_cycle", cyc, head.due);
        checkOutput("duty_value", duty, head.value);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int startValid;
    int busyHigh;
    reset = 1'b0;
    tick = 1'b0;
    control_mode = '0;
    setpoint = '0;
    encoder0_position = '0;
    displacement = '0;
    Kp = '0;
    Ki = '0;
    Kd = '0;
    PWMLimit = '0;
    IntegralLimit = '0;
    deadband = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_duty", duty, 0);
    checkOutput("reset_duty_valid", duty_valid, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b1;

    $display("[TB] P only with busy window");
    applyStimulus(0, 100, 40, 0, 10, 0, 0, LIM_ALL, LIM_ALL, 0, 1'b0, 1'b0, n);
    busyHigh = busy ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK);
      #1;
      if (k <= 5 && busy) busyHigh++;
      if (k == 6) checkOutput("busy_low_after_out", busy, 0);
    end
    checkOutput("busy_high_cycles", busyHigh, 6);
    waitIdle(1'b0);
    checkOutput("p_only_duty", duty, 600);

    $display("[TB] output clamp");
    applyStimulus(0, 1000000, 0, 0, 10, 0, 0, 5000, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("clamp_pos", duty, 5000);
    applyStimulus(0, -1000000, 0, 0, 10, 0, 0, 5000, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("clamp_neg", duty, -5000);
    applyStimulus(0, 8388607, 0, 0, 1, 0, 0, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("clamp_full_scale", duty, 8388607);

    $display("[TB] deadband and windup");
    applyStimulus(0, 5, 0, 0, 1, 0, 0, LIM_ALL, LIM_ALL, 5, 1'b1, 1'b0, n);
    checkOutput("deadband_inside", duty, 0);
    applyStimulus(0, 6, 0, 0, 1, 0, 0, LIM_ALL, LIM_ALL, 5, 1'b1, 1'b0, n);
    checkOutput("deadband_outside", duty, 6);
    doReset();
    applyStimulus(0, 100, 0, 0, 0, 1, 0, LIM_ALL, 250, 0, 1'b1, 1'b0, n);
    checkOutput("windup_1", duty, 100);
    applyStimulus(0, 100, 0, 0, 0, 1, 0, LIM_ALL, 250, 0, 1'b1, 1'b0, n);
    checkOutput("windup_2", duty, 200);
    applyStimulus(0, 100, 0, 0, 0, 1, 0, LIM_ALL, 250, 0, 1'b1, 1'b0, n);
    checkOutput("windup_3", duty, 250);
    applyStimulus(0, 100, 0, 0, 0, 1, 0, LIM_ALL, 250, 0, 1'b1, 1'b0, n);
    checkOutput("windup_4", duty, 250);

    $display("[TB] derivative and velocity");
    doReset();
    applyStimulus(0, 10, 0, 0, 0, 0, 2, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("deriv_1", duty, 20);
    applyStimulus(0, 30, 0, 0, 0, 0, 2, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("deriv_2", duty, 40);
    applyStimulus(1, 5, 12, 0, 1, 0, 0, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("velocity_first", duty, -7);

    $display("[TB] direct and unknown modes");
    applyStimulus(3, -300, 0, 0, 0, 0, 0, 200, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("direct_clamp", duty, -200);
    applyStimulus(7, 500, 0, 0, 1, 1, 1, 200, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("unknown_zero", duty, 0);
    applyStimulus(0, 10, 0, 0, 0, 1, 0, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("integ_cleared", duty, 10);

    $display("[TB] ignored ticks while busy and at OUT");
    startValid = validCount;
    applyStimulus(0, 50, 0, 0, 1, 0, 0, LIM_ALL, LIM_ALL, 0, 1'b0, 1'b0, n);
    while (cyc < n + 2) @(negedge CLK);
    setpoint = 24'sd999;
    tick = 1'b1;
    @(negedge CLK);
    tick = 1'b0;
    while (cyc < n + 5) @(negedge CLK);
    tick = 1'b1;
    @(negedge CLK);
    tick = 1'b0;
    waitIdle(1'b0);
    repeat (10) @(negedge CLK);
    checkOutput("busy_single_valid", validCount - startValid, 1);
    checkOutput("busy_duty", duty, 50);

    $display("[TB] reset mid-computation");
    startValid = validCount;
    applyStimulus(0, 50, 30, 0, 1, 1, 1, LIM_ALL, LIM_ALL, 0, 1'b0, 1'b0, n);
    while (cyc < n + 2) @(negedge CLK);
    reset = 1'b0;
    scoreQ.delete();
    modelReset();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    checkOutput("abort_duty", duty, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (10) @(negedge CLK);
    checkOutput("abort_no_valid", validCount - startValid, 0);
    applyStimulus(0, 10, 0, 0, 0, 1, 1, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("post_reset_history", duty, 20);
    applyStimulus(1, 10, 4, 0, 1, 0, 0, LIM_ALL, LIM_ALL, 0, 1'b1, 1'b0, n);
    checkOutput("post_reset_velocity", duty, 6);

    $display("[TB] randomized ticks");
    for (int t = 0; t < 60; t++) begin
      int r;
      int mode;
      longint sp, enc, disp, kp, ki, kd, pwm, ilim, db;
      r = $urandom_range(0, 9);
      if (r < 3) mode = 0;
      else if (r < 6) mode = 1;
      else if (r < 8) mode = 2;
      else if (r == 8) mode = 3;
      else mode = $urandom_range(4, 255);
      sp = $urandom_range(0, 1) ? rand24s() : longint'($urandom_range(0, 2000)) - 1000;
      enc = longint'($urandom_range(0, 4194303)) - 2097152;
      if ($urandom_range(0, 1)) enc = longint'($urandom_range(0, 2000)) - 1000;
      disp = rand24s();
      kp = $urandom_range(0, 1) ? longint'($urandom_range(0, 40)) - 20 : rand24s();
      ki = $urandom_range(0, 1) ? longint'($urandom_range(0, 40)) - 20 : rand24s();
      kd = $urandom_range(0, 1) ? longint'($urandom_range(0, 40)) - 20 : rand24s();
      pwm = $urandom_range(0, 1) ? longint'($urandom_range(0, 16777215)) : longint'($urandom_range(0, 100000));
      ilim = $urandom_range(0, 1) ? longint'($urandom_range(0, 16777215)) : longint'($urandom_range(0, 5000));
      db = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 16777215)) : longint'($urandom_range(0, 20));
      applyStimulus(mode, sp, enc, disp, kp, ki, kd, pwm, ilim, db, 1'b1, 1'b1, n);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    waitIdle(1'b0);
    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
